// File: rtl/soc_mem_pkg.sv
// Shared types and constants for the SOC memory port arbiter.
package soc_mem_pkg;

   localparam int MASK_W = 4;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/memory-stage requesters, the arbiter
// and the memory array. The arbiter uses the slave view; the requesters
// and memory together form the master view.
interface mem_port_arbiter_if
   import soc_mem_pkg::*;
#(
   parameter int ADDR_W = 8
);

   logic                iReq;
   logic [ADDR_W-1:0]   iAddr;
   logic                iGrant;
   logic                iValid;
   logic [WORD_W-1:0]   iRdata;

   logic                dReq;
   logic                dWe;
   logic [ADDR_W-1:0]   dAddr;
   logic [WORD_W-1:0]   dWdata;
   logic [MASK_W-1:0]   dMask;
   logic                dGrant;
   logic                dValid;
   logic [WORD_W-1:0]   dRdata;

   logic                err;

   logic                memReq;
   logic                memWe;
   logic [MASK_W-1:0]   memMask;
   logic [ADDR_W-1:0]   memAddr;
   logic [WORD_W-1:0]   memWdata;
   logic [WORD_W-1:0]   memRdata;
   logic                memAck;

   modport slave (
      input  iReq, iAddr, dReq, dWe, dAddr, dWdata, dMask, memRdata, memAck,
      output iGrant, iValid, iRdata, dGrant, dValid, dRdata, err,
             memReq, memWe, memMask, memAddr, memWdata
   );

   modport master (
      output iReq, iAddr, dReq, dWe, dAddr, dWdata, dMask, memRdata, memAck,
      input  iGrant, iValid, iRdata, dGrant, dValid, dRdata, err,
             memReq, memWe, memMask, memAddr, memWdata
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational two-way picker between fetch and data requests.
// Build option MEM_ARB_RR_EN: ties alternate using the last-winner input;
// without it, data always wins a tie and lastWinner is ignored.
module mem_arb_pick
   import soc_mem_pkg::*;
(
   input  logic   iReq,
   input  logic   dReq,
   input  owner_e lastWinner,
   output logic   pickI,
   output logic   pickD
);

   // A lone request always wins; a tie is resolved by the build's policy.
   always_comb begin
      pickI = 1'b0;
      pickD = 1'b0;
      if (iReq && dReq) begin
`ifdef MEM_ARB_RR_EN
         pickD = (lastWinner == OWN_I);
         pickI = (lastWinner == OWN_D);
`else
         pickD = 1'b1;
`endif
      end else begin
         pickI = iReq;
         pickD = dReq;
      end
   end

`ifdef MEM_ARB_RR_EN
`else
   logic unusedLastWinner;
   assign unusedLastWinner = lastWinner;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single 256-word SOC memory between instruction fetch and
// the memory stage, with a bounded-wait watchdog on each transaction.
// Build option MEM_ARB_RR_EN: round-robin on simultaneous requests;
// default build is fixed priority with data over fetch.
module mem_port_arbiter
   import soc_mem_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 15
)(
   input logic                CLK,
   input logic                RESET,
   mem_port_arbiter_if.slave  bus
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_e     state;
   logic [7:0] wdCount;
   owner_e     lastWinner;
   logic       pickI;
   logic       pickD;

   mem_arb_pick uPick (
      .iReq       (bus.iReq),
      .dReq       (bus.dReq),
      .lastWinner (lastWinner),
      .pickI      (pickI),
      .pickD      (pickD)
   );

`ifdef MEM_ARB_RR_EN
   // Remember who won the most recent grant so the other side wins the next tie.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         lastWinner <= OWN_I;
      end else if (state == IDLE && (pickI || pickD)) begin
         lastWinner <= pickD ? OWN_D : OWN_I;
      end
   end
`else
   assign lastWinner = OWN_I;
`endif

   // Main sequencer: accept in IDLE, wait for ack or watchdog while busy.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state        <= IDLE;
         wdCount      <= 8'd0;
         bus.iGrant   <= 1'b0;
         bus.iValid   <= 1'b0;
         bus.iRdata   <= '0;
         bus.dGrant   <= 1'b0;
         bus.dValid   <= 1'b0;
         bus.dRdata   <= '0;
         bus.err      <= 1'b0;
         bus.memReq   <= 1'b0;
         bus.memWe    <= 1'b0;
         bus.memMask  <= '0;
         bus.memAddr  <= '0;
         bus.memWdata <= '0;
      end else begin
         bus.iGrant <= 1'b0;
         bus.dGrant <= 1'b0;
         bus.iValid <= 1'b0;
         bus.dValid <= 1'b0;
         bus.err    <= 1'b0;
         bus.memReq <= 1'b0;
         case (state)
            IDLE: begin
               if (pickD) begin
                  bus.dGrant   <= 1'b1;
                  bus.memReq   <= 1'b1;
                  bus.memWe    <= bus.dWe;
                  bus.memMask  <= bus.dMask;
                  bus.memAddr  <= bus.dAddr;
                  bus.memWdata <= bus.dWdata;
                  wdCount      <= 8'd1;
                  state        <= BUSY_D;
               end else if (pickI) begin
                  bus.iGrant   <= 1'b1;
                  bus.memReq   <= 1'b1;
                  bus.memWe    <= 1'b0;
                  bus.memMask  <= '0;
                  bus.memAddr  <= bus.iAddr;
                  bus.memWdata <= '0;
                  wdCount      <= 8'd1;
                  state        <= BUSY_I;
               end
            end
            BUSY_I: begin
               if (bus.memAck) begin
                  bus.iValid <= 1'b1;
                  bus.iRdata <= bus.memRdata;
                  wdCount    <= 8'd0;
                  state      <= IDLE;
               end else if (wdCount == TIMEOUT_CNT) begin
                  bus.iValid <= 1'b1;
                  bus.err    <= 1'b1;
                  wdCount    <= 8'd0;
                  state      <= IDLE;
               end else begin
                  wdCount <= wdCount + 8'd1;
               end
            end
            BUSY_D: begin
               if (bus.memAck) begin
                  bus.dValid <= 1'b1;
                  if (!bus.memWe) begin
                     bus.dRdata <= bus.memRdata;
                  end
                  wdCount <= 8'd0;
                  state   <= IDLE;
               end else if (wdCount == TIMEOUT_CNT) begin
                  bus.dValid <= 1'b1;
                  bus.err    <= 1'b1;
                  wdCount    <= 8'd0;
                  state      <= IDLE;
               end else begin
                  wdCount <= wdCount + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a simple latency-programmable
// memory responder. Expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;

   logic CLK;
   logic RESET;

   mem_port_arbiter_if #(.ADDR_W(8)) bus ();

   mem_port_arbiter #(.ADDR_W(8), .TIMEOUT(15)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   int          testsRun  = 0;
   int          failCount = 0;
   int          memLatency = 1;
   int          memCount   = 0;
   logic        forceAck   = 1'b0;
   logic [31:0] memWord    = 32'h0;

   // Free-running clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Memory responder: acks memLatency cycles after the memReq cycle.
   initial begin
      bus.memAck   = 1'b0;
      bus.memRdata = 32'h0;
      forever begin
         @(posedge CLK);
         #2;
         bus.memAck = 1'b0;
         if (RESET) begin
            memCount = 0;
         end else begin
            if (memCount > 0) begin
               memCount = memCount - 1;
               if (memCount == 0) begin
                  bus.memAck   = 1'b1;
                  bus.memRdata = memWord;
               end
            end
            if (bus.memReq && memLatency > 0) memCount = memLatency;
            if (forceAck) bus.memAck = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic iReq, input logic [7:0] iAddr,
                                input logic dReq, input logic dWe,
                                input logic [7:0] dAddr, input logic [31:0] dWdata,
                                input logic [3:0] dMask);
      bus.iReq   = iReq;
      bus.iAddr  = iAddr;
      bus.dReq   = dReq;
      bus.dWe    = dWe;
      bus.dAddr  = dAddr;
      bus.dWdata = dWdata;
      bus.dMask  = dMask;
   endtask

   function automatic logic [148:0] allOutputs();
      return {bus.iGrant, bus.iValid, bus.iRdata, bus.dGrant, bus.dValid,
              bus.dRdata, bus.err, bus.memReq, bus.memWe, bus.memMask,
              bus.memAddr, bus.memWdata};
   endfunction

   task automatic test_reset();
      RESET = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
      tick();
      tick();
      testsRun++;
      if (allOutputs() !== 149'd0) begin
         failCount++;
         $display("[TB] FAIL resetOutputs: got %h want 0", allOutputs());
      end
      RESET = 1'b0;
   endtask

   task automatic test_lone_fetch();
      memLatency = 1;
      memWord    = 32'h00100093;
      applyStimulus(1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
      tick();
      testsRun++;
      if ({bus.iGrant, bus.memReq, bus.memWe, bus.memMask, bus.memAddr} !== {1'b1, 1'b1, 1'b0, 4'h0, 8'h04}) begin
         failCount++;
         $display("[TB] FAIL fetchGrant: got g=%b req=%b we=%b mask=%h addr=%h want 1 1 0 0 04",
                  bus.iGrant, bus.memReq, bus.memWe, bus.memMask, bus.memAddr);
      end
      bus.iReq = 1'b0;
      tick();
      testsRun++;
      if ({bus.iGrant, bus.memReq, bus.iValid} !== 3'b000) begin
         failCount++;
         $display("[TB] FAIL fetchCycle2: got g=%b req=%b v=%b want 0 0 0", bus.iGrant, bus.memReq, bus.iValid);
      end
      tick();
      testsRun++;
      if ({bus.iValid, bus.dValid, bus.err, bus.iRdata} !== {3'b100, 32'h00100093}) begin
         failCount++;
         $display("[TB] FAIL fetchValid: got iv=%b dv=%b err=%b data=%h want 1 0 0 00100093",
                  bus.iValid, bus.dValid, bus.err, bus.iRdata);
      end
      tick();
      testsRun++;
      if ({bus.iValid, bus.memAddr} !== {1'b0, 8'h04}) begin
         failCount++;
         $display("[TB] FAIL fetchAfter: got iv=%b addr=%h want 0 04", bus.iValid, bus.memAddr);
      end
   endtask

   task automatic test_store_load();
      memLatency = 1;
      memWord    = 32'h12345678;
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 32'hDEADBEEF, 4'b0011);
      tick();
      testsRun++;
      if ({bus.dGrant, bus.memReq, bus.memWe, bus.memMask, bus.memAddr, bus.memWdata} !==
          {1'b1, 1'b1, 1'b1, 4'b0011, 8'h06, 32'hDEADBEEF}) begin
         failCount++;
         $display("[TB] FAIL storeCmd: got g=%b req=%b we=%b mask=%h addr=%h wd=%h want 1 1 1 3 06 deadbeef",
                  bus.dGrant, bus.memReq, bus.memWe, bus.memMask, bus.memAddr, bus.memWdata);
      end
      bus.dReq = 1'b0;
      tick();
      tick();
      testsRun++;
      if ({bus.dValid, bus.err, bus.iValid, bus.dRdata} !== {3'b100, 32'h0}) begin
         failCount++;
         $display("[TB] FAIL storeDone: got dv=%b err=%b iv=%b rd=%h want 1 0 0 00000000",
                  bus.dValid, bus.err, bus.iValid, bus.dRdata);
      end
      memWord = 32'hCAFEF00D;
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h07, 32'h0, 4'h0);
      tick();
      bus.dReq = 1'b0;
      testsRun++;
      if ({bus.dGrant, bus.memWe, bus.memAddr} !== {1'b1, 1'b0, 8'h07}) begin
         failCount++;
         $display("[TB] FAIL loadCmd: got g=%b we=%b addr=%h want 1 0 07", bus.dGrant, bus.memWe, bus.memAddr);
      end
      tick();
      tick();
      testsRun++;
      if ({bus.dValid, bus.dRdata} !== {1'b1, 32'hCAFEF00D}) begin
         failCount++;
         $display("[TB] FAIL loadData: got dv=%b rd=%h want 1 cafef00d", bus.dValid, bus.dRdata);
      end
   endtask

   task automatic test_back_to_back();
      logic expD [4];
`ifdef MEM_ARB_RR_EN
      expD = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      expD = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      memLatency = 1;
      memWord    = 32'h0BADC0DE;
      applyStimulus(1'b1, 8'h20, 1'b1, 1'b0, 8'h30, 32'h0, 4'h0);
      for (int t = 0; t < 4; t++) begin
         tick();
         testsRun++;
         if ({bus.dGrant, bus.iGrant} !== {expD[t], ~expD[t]}) begin
            failCount++;
            $display("[TB] FAIL tieGrant%0d: got d=%b i=%b want d=%b i=%b",
                     t, bus.dGrant, bus.iGrant, expD[t], ~expD[t]);
         end
         if (t == 3) begin
            bus.iReq = 1'b0;
            bus.dReq = 1'b0;
         end
         tick();
         tick();
         testsRun++;
         if ({bus.dValid, bus.iValid} !== {expD[t], ~expD[t]}) begin
            failCount++;
            $display("[TB] FAIL tieValid%0d: got d=%b i=%b want d=%b i=%b",
                     t, bus.dValid, bus.iValid, expD[t], ~expD[t]);
         end
      end
      tick();
      testsRun++;
      if (bus.dRdata !== 32'h0BADC0DE) begin
         failCount++;
         $display("[TB] FAIL tieRdata: got %h want 0badc0de", bus.dRdata);
      end
   endtask

   task automatic test_timeout();
      int earlyPulses = 0;
      int lateEvents  = 0;
      memLatency = 0;
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h09, 32'h0, 4'h0);
      tick();
      bus.dReq = 1'b0;
      testsRun++;
      if (bus.dGrant !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL wdGrant: got %b want 1", bus.dGrant);
      end
      for (int c = 2; c <= 15; c++) begin
         tick();
         if (bus.dValid || bus.err) earlyPulses++;
      end
      testsRun++;
      if (earlyPulses !== 0) begin
         failCount++;
         $display("[TB] FAIL wdEarly: got %0d pulses want 0", earlyPulses);
      end
      tick();
      testsRun++;
      if ({bus.dValid, bus.err, bus.iValid, bus.dRdata} !== {3'b110, 32'h0BADC0DE}) begin
         failCount++;
         $display("[TB] FAIL wdAbort: got dv=%b err=%b iv=%b rd=%h want 1 1 0 0badc0de",
                  bus.dValid, bus.err, bus.iValid, bus.dRdata);
      end
      tick();
      testsRun++;
      if ({bus.dValid, bus.err} !== 2'b00) begin
         failCount++;
         $display("[TB] FAIL wdAfter: got dv=%b err=%b want 0 0", bus.dValid, bus.err);
      end
      forceAck = 1'b1;
      tick();
      forceAck = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (bus.dValid || bus.iValid || bus.err || bus.dGrant || bus.iGrant) lateEvents++;
      end
      testsRun++;
      if (lateEvents !== 0) begin
         failCount++;
         $display("[TB] FAIL strayAck: got %0d events want 0", lateEvents);
      end
   endtask

   task automatic test_reset_mid();
      int validSeen = 0;
      logic [31:0] lastData = 32'h0;
      memLatency = 5;
      memWord    = 32'h00000013;
      applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
      tick();
      bus.iReq = 1'b0;
      testsRun++;
      if ({bus.iGrant, bus.memAddr} !== {1'b1, 8'h10}) begin
         failCount++;
         $display("[TB] FAIL midGrant: got g=%b addr=%h want 1 10", bus.iGrant, bus.memAddr);
      end
      tick();
      RESET = 1'b1;
      #1;
      testsRun++;
      if (allOutputs() !== 149'd0) begin
         failCount++;
         $display("[TB] FAIL midReset: got %h want 0", allOutputs());
      end
      tick();
      RESET = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (bus.iValid) validSeen++;
      end
      testsRun++;
      if (validSeen !== 0) begin
         failCount++;
         $display("[TB] FAIL abandoned: got %0d valid pulses want 0", validSeen);
      end
      bus.iReq  = 1'b1;
      bus.iAddr = 8'h11;
      tick();
      bus.iReq = 1'b0;
      testsRun++;
      if ({bus.iGrant, bus.memReq, bus.memAddr} !== {1'b1, 1'b1, 8'h11}) begin
         failCount++;
         $display("[TB] FAIL freshGrant: got g=%b req=%b addr=%h want 1 1 11", bus.iGrant, bus.memReq, bus.memAddr);
      end
      for (int c = 0; c < 8; c++) begin
         tick();
         if (bus.iValid) begin
            validSeen++;
            lastData = bus.iRdata;
         end
      end
      testsRun++;
      if ({validSeen[7:0], lastData} !== {8'd1, 32'h00000013}) begin
         failCount++;
         $display("[TB] FAIL freshDone: got %0d pulses data %h want 1 00000013", validSeen, lastData);
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      RESET = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
      test_reset();
      test_lone_fetch();
      test_store_load();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single word-addressed instruction/data memory of the RV32I SOC between two requesters: the fetch stage (read-only) and the memory stage (load/store). Each transaction is a registered request/grant/response sequence with a bounded-wait watchdog. The block sits between the processor state machine and the 256-word memory array, and turns memory access into a handshake the sequencer can stall on.

## Interface
Parameters:
- ADDR_W, 8: word address width (256 words).
- TIMEOUT, 15: maximum busy cycles without memAck before abort; legal range 2..255.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- iReq  in  1  fetch request; held high until iGrant is seen.
- iAddr  in  ADDR_W  fetch word address.
- iGrant  out  1  one-cycle pulse when the fetch is accepted.
- iValid  out  1  one-cycle pulse when the fetch completes.
- iRdata  out  32  fetched word, valid with iValid.
- dReq  in  1  data request; held until dGrant.
- dWe  in  1  1 = store, 0 = load.
- dAddr  in  ADDR_W  data word address.
- dWdata  in  32  store data.
- dMask  in  4  store byte enables; bit n enables byte n.
- dGrant  out  1  one-cycle accept pulse.
- dValid  out  1  one-cycle completion pulse (loads and stores).
- dRdata  out  32  load data, valid with dValid.
- err  out  1  one-cycle pulse, coincident with i/dValid, on watchdog abort.
- memReq  out  1  one-cycle strobe to memory.
- memWe, memMask, memAddr, memWdata  out  1/4/ADDR_W/32  command to memory, stable for the whole busy period.
- memRdata  in  32  read data, valid with memAck.
- memAck  in  1  completion from memory.

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: if exactly one request is high, accept it. If both are high, select per Configuration. On acceptance, latch address, we, mask and wdata; go to BUSY_I or BUSY_D. Fetch commands are always memWe=0, memMask=4'b0000.
- BUSY_x: sample memAck every cycle, including the memReq cycle.
  - On memAck: a read captures memRdata into x's rdata register; a write leaves rdata unchanged. Pulse xValid, return to IDLE.
- Watchdog: an 8-bit counter loads 1 on acceptance and increments each BUSY cycle without ack. When the count equals TIMEOUT with no ack:
  - pulse xValid and err together;
  - leave rdata unchanged;
  - return to IDLE.
- memAck in IDLE is ignored. This covers late acks after an abort.
- A requester that keeps req high after its grant has issued a new request.
- Requests arriving while BUSY wait; they are not dropped.
- Reset, including mid-transaction: state IDLE; counter 0; priority pointer set so data is favoured. All outputs 0: grants, valids, err, memReq, memWe, memMask, memAddr, memWdata, iRdata, dRdata. A transaction in flight is abandoned without a valid pulse.

## Timing
- Cycle 0: req high in IDLE.
- Cycle 1: grant=1, memReq=1, state BUSY, command outputs valid. Grant and memReq are registered; there is no combinational path from req.
- Cycle k ≥ 1: memAck high.
- Cycle k+1: xValid=1 and rdata valid; state IDLE. A request sampled in this cycle is granted at k+2.
- A 1-cycle memory (ack at cycle 2) gives 3-cycle latency and one transaction per 3 cycles.
- Abort: valid and err at cycle TIMEOUT+1.
- Command outputs hold their values after completion until the next acceptance. memReq is high only in the first busy cycle.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on simultaneous requests. A one-bit last-winner register makes the loser of the previous contested or uncontested grant win the next tie.
- MEM_ARB_RR_EN undefined: fixed priority, data over fetch. No pointer register is built.
- Single-request behaviour is identical in both builds.

## Structure
- Shared package soc_mem_pkg:
  - state enum (IDLE, BUSY_I, BUSY_D);
  - owner encoding (OWN_I, OWN_D);
  - MASK_W=4 and WORD_W=32 constants.
- Sub-module mem_arb_pick: combinational two-way picker. Inputs: iReq, dReq, last-winner. Outputs: pickI, pickD. Instantiated once; it contains the MEM_ARB_RR_EN conditional logic.

## Test plan
- Lone fetch iAddr=8'h04, 1-cycle memory returning 32'h00100093 -> iGrant at cycle 1, iValid and iRdata=32'h00100093 at cycle 3, dValid stays 0.
- Store dAddr=8'h06, dWdata=32'hDEADBEEF, dMask=4'b0011 -> memWe=1, memMask=4'b0011, memAddr=8'h06; dValid at cycle 3; dRdata unchanged.
- iReq and dReq both held high for 4 transactions:
  - fixed build: grants D,D,D,D;
  - MEM_ARB_RR_EN build: grants D,I,D,I.
- memAck never asserted, TIMEOUT=15 -> dValid and err pulse together at cycle 16; a later stray memAck produces no pulse.
- RESET asserted at cycle 2 of a fetch with a 5-cycle memory -> all outputs 0 immediately; no iValid follows; a fresh iReq after release is granted one cycle later.
